sub_alu: RTL and testbench
==========================

SUB_ALU -- requirements
Module: sub_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits.
REQ-002 SHALL have port sysclk  input  1  single clock, all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream presents an operation.
REQ-005 SHALL have port in_ready  output  1  block accepts the operation this cycle.
REQ-006 SHALL have port op_sel  input  2  operation: 00 dec (a-1), 01 sub (a-b), 10 rsub (b-a), 11 neg (0-a).
REQ-007 SHALL have port op_a  input  WIDTH  first operand.
REQ-008 SHALL have port op_b  input  WIDTH  second operand, ignored for dec and neg.
REQ-009 SHALL have port out_valid  output  1  result presented downstream.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port result  output  WIDTH  difference, modulo 2^WIDTH.
REQ-012 SHALL have port borrow  output  1  unsigned borrow: minuend < subtrahend.
REQ-013 SHALL have port zero  output  1  result == 0.
REQ-014 SHALL have port ovf  output  1  signed two's-complement overflow.
REQ-015 SHALL have port op_count  output  16  number of results accepted downstream.

Function
REQ-016 SHALL use a 2-stage pipeline: S1 registers the operands and decodes the operation; S2 registers result and flags.
REQ-017 SHALL make latency 2 cycles from the in_valid&in_ready edge to out_valid with no backpressure; throughput SHALL be 1 op/cycle.
REQ-018 SHALL set a transfer on either side only on a cycle where valid and ready are both high at the rising edge.
REQ-019 SHALL let each stage advance when it is empty or its content moves on this cycle; in_ready = !s1_valid | s1_advance, combinational from state and out_ready.
REQ-020 SHALL hold S2 contents and flags stable while out_valid=1 and out_ready=0; no result SHALL be lost or duplicated.
REQ-021 SHALL compute over WIDTH+1 bits; borrow = bit WIDTH of the extended difference.
REQ-022 SHALL set ovf = (sign(minuend) != sign(subtrahend)) & (sign(result) != sign(minuend)).
REQ-023 SHALL give dec of 0x00 as 0xFF with borrow=1, and dec of 0x80 as 0x7F with ovf=1.
REQ-024 SHALL give neg of 0x00 as 0x00 with borrow=0 and zero=1, and neg of 0x80 as 0x80 with ovf=1 and borrow=1.
REQ-025 SHALL increment op_count on each out_valid&out_ready and wrap from 0xFFFF to 0x0000.
REQ-026 SHALL, on simultaneous accept and retire with a full pipeline, move S1 into S2 and load the new operation into S1 in the same cycle.
REQ-027 SHALL, for an undriven or X op_sel during in_valid=0, leave state unchanged.

Reset
REQ-028 SHALL, while rst_n=0, force out_valid=0, result=0, borrow=0, zero=0, ovf=0, op_count=0, and both stage valids to 0, independent of sysclk.
REQ-029 SHALL drop any in-flight operations when reset asserts mid-operation; none SHALL be presented after release.
REQ-030 SHALL give in_ready=1 on the first clock edge after rst_n deasserts.

Structure
REQ-031 SHALL place the op_sel encodings (OP_DEC, OP_SUB, OP_RSUB, OP_NEG) and the default WIDTH in a shared package alu_pkg, used by all ALU blocks.
REQ-032 SHALL put the subtract-and-flags datapath in one combinational sub-module, sub_alu_core (inputs minuend, subtrahend; outputs result, borrow, zero, ovf); pipeline and handshake logic SHALL stay in sub_alu.

Verification
REQ-033 Dec stream: op_a=0x05,0x01,0x00 back-to-back, out_ready=1 -> results 0x04,0x00(zero=1),0xFF(borrow=1) on cycles 2,3,4; op_count=3.
REQ-034 Sub overflow: sub a=0x80,b=0x01 -> 0x7F, ovf=1, borrow=0; rsub a=0x01,b=0x80 -> 0x7F, ovf=1.
REQ-035 Backpressure: issue 4 ops with out_ready=0 -> in_ready low after 2 accepts; result held stable; release -> 4 results in order, no loss or duplicate.
REQ-036 Neg corners: neg 0x00 -> 0x00, zero=1, borrow=0; neg 0x80 -> 0x80, ovf=1, borrow=1.
REQ-037 Reset mid-flight: 2 ops in pipeline, pulse rst_n low between edges -> outputs zero at once, no results after release, op_count=0.
REQ-038 Counter wrap: preload 0xFFFF completions (force or long run), one more retire -> op_count=0x0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU blocks.
//   ALU_WIDTH : default operand/result width in bits
//   alu_op_e  : op_sel encodings (dec, sub, rsub, neg)
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_DEC  = 2'b00,  // a - 1
    OP_SUB  = 2'b01,  // a - b
    OP_RSUB = 2'b10,  // b - a
    OP_NEG  = 2'b11   // 0 - a
  } alu_op_e;

endpackage

// File: rtl/sub_alu_core.sv
// Combinational subtract-and-flags datapath.
//   minuend, subtrahend : WIDTH-bit operands
//   result              : minuend - subtrahend, modulo 2^WIDTH
//   borrow              : unsigned borrow (minuend < subtrahend)
//   zero                : result == 0
//   ovf                 : signed two's-complement overflow
module sub_alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  // Zero-extended by one bit so the top bit of the difference is the borrow.
  logic [WIDTH:0] diff;

  always_comb begin
    diff   = {1'b0, minuend} - {1'b0, subtrahend};
    result = diff[WIDTH-1:0];
    borrow = diff[WIDTH];
    zero   = (diff[WIDTH-1:0] == '0);
    // Overflow only possible when operand signs differ; it shows as the
    // result sign flipping away from the minuend sign.
    ovf    = (minuend[WIDTH-1] != subtrahend[WIDTH-1]) &&
             (diff[WIDTH-1] != minuend[WIDTH-1]);
  end

endmodule

// File: rtl/sub_alu.sv
// Two-stage pipelined subtract ALU with valid/ready handshakes.
//   sysclk, rst_n        : clock, asynchronous active-low reset
//   in_valid, in_ready   : upstream handshake
//   op_sel, op_a, op_b   : operation and operands
//   out_valid, out_ready : downstream handshake
//   result, borrow, zero, ovf : registered difference and flags
//   op_count             : results accepted downstream, wraps at 16 bits
// S1 holds the decoded minuend/subtrahend pair; S2 holds result and flags.
module sub_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             zero,
  output logic             ovf,
  output logic [15:0]      op_count
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_min_q, s1_sub_q;
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_result_q;
  logic             s2_borrow_q, s2_zero_q, s2_ovf_q;
  logic [15:0]      count_q;

  logic             s2_ready, s1_advance, accept, retire;
  logic [WIDTH-1:0] dec_min, dec_sub;
  logic [WIDTH-1:0] core_result;
  logic             core_borrow, core_zero, core_ovf;

  // Handshake: a stage can take new content when empty or draining this cycle.
  always_comb begin
    s2_ready   = !s2_valid_q || out_ready;
    s1_advance = s1_valid_q && s2_ready;
    in_ready   = !s1_valid_q || s1_advance;
    accept     = in_valid && in_ready;
    retire     = s2_valid_q && out_ready;
  end

  // Map every operation onto a plain minuend - subtrahend.
  always_comb begin
    dec_min = op_a;
    dec_sub = op_b;
    case (alu_op_e'(op_sel))
      OP_DEC:  begin dec_min = op_a; dec_sub = WIDTH'(1); end
      OP_SUB:  begin dec_min = op_a; dec_sub = op_b;      end
      OP_RSUB: begin dec_min = op_b; dec_sub = op_a;      end
      OP_NEG:  begin dec_min = '0;   dec_sub = op_a;      end
      default: begin dec_min = op_a; dec_sub = op_b;      end
    endcase
  end

  sub_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .minuend    (s1_min_q),
    .subtrahend (s1_sub_q),
    .result     (core_result),
    .borrow     (core_borrow),
    .zero       (core_zero),
    .ovf        (core_ovf)
  );

  // Stage 1: operand registers. Data only loads on an accepted transfer, so
  // garbage on op_sel/op_a/op_b while idle never reaches state.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_min_q   <= '0;
      s1_sub_q   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (accept) begin
        s1_min_q <= dec_min;
        s1_sub_q <= dec_sub;
      end
    end
  end

  // Stage 2: result and flags, held while downstream stalls.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_borrow_q <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_ovf_q    <= 1'b0;
    end else begin
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s1_advance) begin
        s2_result_q <= core_result;
        s2_borrow_q <= core_borrow;
        s2_zero_q   <= core_zero;
        s2_ovf_q    <= core_ovf;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + 16'd1;
    end
  end

  always_comb begin
    out_valid = s2_valid_q;
    result    = s2_result_q;
    borrow    = s2_borrow_q;
    zero      = s2_zero_q;
    ovf       = s2_ovf_q;
    op_count  = count_q;
  end

endmodule

// File: tb/tb_sub_alu.sv
module tb_sub_alu;

  typedef struct packed {
    logic [7:0] res;
    logic       b;
    logic       z;
    logic       o;
  } exp_t;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [1:0] op_sel;
  logic [7:0] op_a, op_b;
  logic       out_valid, out_ready;
  logic [7:0] result;
  logic       borrow, zero, ovf;
  logic [15:0] op_count;

  int         n_checks = 0;
  int         n_err    = 0;
  exp_t       exp_q[$];
  logic [15:0] exp_count = '0;

  always #5 sysclk = ~sysclk;

  sub_alu #(
    .WIDTH (8)
  ) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sel    (op_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .borrow    (borrow),
    .zero      (zero),
    .ovf       (ovf),
    .op_count  (op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned compare for borrow, integer range test for overflow.
  function automatic exp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] m, s;
    int sm, ss, sd;
    exp_t e;
    case (op)
      2'b00:   begin m = a;     s = 8'd1; end
      2'b01:   begin m = a;     s = b;    end
      2'b10:   begin m = b;     s = a;    end
      default: begin m = 8'd0;  s = a;    end
    endcase
    sm = $signed(m);
    ss = $signed(s);
    sd = sm - ss;
    e.res = m - s;
    e.b   = (m < s);
    e.z   = (e.res == 8'd0);
    e.o   = (sd > 127) || (sd < -128);
    return e;
  endfunction

  // Scoreboard: pop and compare on every downstream transfer.
  always @(negedge sysclk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL spurious_result: observed %0h expected none", result);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("borrow", 32'(borrow), 32'(e.b));
        check("zero",   32'(zero),   32'(e.z));
        check("ovf",    32'(ovf),    32'(e.o));
        exp_count = exp_count + 16'd1;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input exp_t e);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    op_sel   = op;
    op_a     = a;
    op_b     = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge sysclk);
      acc = in_ready;
      @(posedge sysclk);
      if (acc) exp_q.push_back(e);
      #1;
      if (!acc) out_ready = 1'b1;
    end
    check("send_accept", 32'(acc), 32'(1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    op_sel   = 2'bxx;
    op_a     = 'x;
    op_b     = 'x;
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge sysclk);
      #1;
    end
    check("drain_empty", 32'(exp_q.size()), 32'(0));
    @(posedge sysclk);
    #1;
    check("op_count", 32'(op_count), 32'(exp_count));
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [1:0] rop;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_sel    = 2'b00;
    op_a      = '0;
    op_b      = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_result",    32'(result),    32'(0));
    check("rst_op_count",  32'(op_count),  32'(0));
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
    @(posedge sysclk);
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'(1));

    // Dec stream back-to-back
    send(2'b00, 8'h05, 8'h00, '{res: 8'h04, b: 1'b0, z: 1'b0, o: 1'b0});
    send(2'b00, 8'h01, 8'h00, '{res: 8'h00, b: 1'b0, z: 1'b1, o: 1'b0});
    send(2'b00, 8'h00, 8'h00, '{res: 8'hFF, b: 1'b1, z: 1'b0, o: 1'b0});
    drain();
    check("dec_stream_count", 32'(op_count), 32'(3));

    // Overflow and negation corners
    send(2'b00, 8'h80, 8'h00, '{res: 8'h7F, b: 1'b0, z: 1'b0, o: 1'b1});
    send(2'b01, 8'h80, 8'h01, '{res: 8'h7F, b: 1'b0, z: 1'b0, o: 1'b1});
    send(2'b10, 8'h01, 8'h80, '{res: 8'h7F, b: 1'b0, z: 1'b0, o: 1'b1});
    send(2'b11, 8'h00, 8'h55, '{res: 8'h00, b: 1'b0, z: 1'b1, o: 1'b0});
    send(2'b11, 8'h80, 8'h00, '{res: 8'h80, b: 1'b1, z: 1'b0, o: 1'b1});
    drain();

    // Backpressure: two accepts fill the pipe, third op must stall
    out_ready = 1'b0;
    send(2'b01, 8'h10, 8'h03, '{res: 8'h0D, b: 1'b0, z: 1'b0, o: 1'b0});
    send(2'b10, 8'h10, 8'h03, '{res: 8'hF3, b: 1'b1, z: 1'b0, o: 1'b0});
    in_valid = 1'b1;
    op_sel   = 2'b00;
    op_a     = 8'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      check("bp_in_ready", 32'(in_ready),  32'(0));
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_result_hold", 32'(result), 32'(8'h0D));
    end
    @(posedge sysclk);
    #1;
    out_ready = 1'b1;
    send(2'b00, 8'h20, 8'h00, '{res: 8'h1F, b: 1'b0, z: 1'b0, o: 1'b0});
    send(2'b11, 8'h01, 8'h00, '{res: 8'hFF, b: 1'b1, z: 1'b0, o: 1'b0});
    drain();

    // Random mix with intermittent downstream stalls
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      send(rop, ra, rb, model(rop, ra, rb));
    end
    out_ready = 1'b1;
    drain();

    // Reset pulse between edges with two ops in flight
    out_ready = 1'b0;
    send(2'b01, 8'h09, 8'h02, model(2'b01, 8'h09, 8'h02));
    send(2'b01, 8'h08, 8'h02, model(2'b01, 8'h08, 8'h02));
    idle(1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_result",    32'(result),    32'(0));
    check("midrst_borrow",    32'(borrow),    32'(0));
    check("midrst_op_count",  32'(op_count),  32'(0));
    exp_q.delete();
    exp_count = '0;
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle(10);
    check("postrst_out_valid", 32'(out_valid), 32'(0));
    check("postrst_op_count",  32'(op_count),  32'(0));

    // Counter wrap from 0xFFFF
    @(negedge sysclk);
    force dut.count_q = 16'hFFFF;
    @(negedge sysclk);
    release dut.count_q;
    exp_count = 16'hFFFF;
    #1;
    check("preload_count", 32'(op_count), 32'(16'hFFFF));
    @(posedge sysclk);
    #1;
    send(2'b00, 8'h02, 8'h00, '{res: 8'h01, b: 1'b0, z: 1'b0, o: 1'b0});
    drain();
    check("wrap_count", 32'(op_count), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
